arith_op_sequencer: RTL
=======================

# arith_op_sequencer

Operand-loading and operation-sequencing controller for the 32-bit integer multiply/divide datapath on the DE2 board. It debounces the load key and assembles two 32-bit operands from four 16-bit switch captures. It then issues one multi-cycle operation to the arithmetic unit over a start/done handshake and holds the result for the display logic. It sits between the board I/O (SW, KEY) and the arithmetic unit; the HEX/LED drivers read `result`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16, consecutive stable cycles required to accept a key level change. Use 500000 on the board.
- `TIMEOUT_CYCLES`, 64, maximum cycles in WAIT before the operation is abandoned.

Ports:
- `CLOCK_50`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load_n`  in  1  raw load key, active-low, asynchronous to the clock.
- `op_sel`  in  1  0 = multiply, 1 = divide. Sampled only on the 4th capture.
- `sw`  in  16  operand half-word.
- `alu_start`  out  1  one-cycle request pulse to the arithmetic unit.
- `alu_op`  out  1  latched `op_sel`.
- `alu_a`, `alu_b`  out  32  operands. Stable from ISSUE through WAIT.
- `alu_done`  in  1  one-cycle completion pulse from the arithmetic unit.
- `alu_result`  in  32  valid in the cycle `alu_done` = 1.
- `result`  out  32  held result.
- `result_valid`  out  1  high while `result` holds a completed operation.
- `load_stage`  out  2  index of the next half-word to capture.
- `busy`  out  1  high in ISSUE and WAIT.
- `div_by_zero`, `timeout`  out  1  error flags, held with `result`.

## Operation
- Key path:
  - `load_n` passes through a 2-flop synchronizer.
  - The debounced level (reset value 1) flips only after the synchronized value differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any matching sample clears the counter.
  - A 1→0 flip of the debounced level gives `press`, a one-cycle internal event. Exactly one `press` is generated per physical press.
- States: LOAD, ISSUE, WAIT, DONE. Reset state is LOAD.
- LOAD: on `press`, capture `sw` according to `load_stage`:
  - 0 → a[15:0]
  - 1 → a[31:16]
  - 2 → b[15:0]
  - 3 → b[31:16]

  Then increment `load_stage` (wraps 3→0).
- 4th capture: latch `op_sel` into `alu_op`. The assembled b includes the `sw` value from this same cycle.
  - If divide and assembled b = 0: skip the ALU. Go to DONE with `result` = 0xFFFFFFFF and `div_by_zero` = 1.
  - Otherwise go to ISSUE.
- ISSUE: `alu_start` = 1 for exactly this one cycle; go to WAIT.
- WAIT:
  - On `alu_done`: `result` ← `alu_result`; go to DONE.
  - After `TIMEOUT_CYCLES` cycles in WAIT without `alu_done`: `result` ← 0xFFFFFFFF, `timeout` = 1; go to DONE.
  - `alu_done` arriving outside WAIT is ignored.
- DONE: `result_valid` = 1. The first `press` does all of the following in one cycle:
  - clears `result_valid`, `div_by_zero` and `timeout`;
  - captures a[15:0];
  - sets `load_stage` = 1;
  - goes to LOAD.

  `result` keeps its old value until overwritten.
- `press` in ISSUE or WAIT is discarded; `load_stage` does not change.
- Reset (any state, including mid-WAIT):
  - all state returns to LOAD with `load_stage` = 0;
  - all outputs become 0: `result`, `alu_a`, `alu_b`, `alu_op`, `alu_start`, `result_valid`, `busy`, flags;
  - the debounced level returns to 1 and the debounce counter to 0.

  A late `alu_done` after reset is ignored.

## Timing
- `press` asserts on the clock edge 2 + `DEBOUNCE_CYCLES` after the first edge that samples `load_n` = 0, provided `load_n` is held low throughout.
- 4th `press` → `alu_start` high in the next cycle.
- `alu_done` in cycle N → `result` and `result_valid` updated at the edge ending cycle N, visible in cycle N+1. `busy` falls in the same cycle.
- Divide-by-zero: `result_valid` is visible in the cycle after the 4th `press`. `alu_start` never asserts.
- Timeout: the WAIT entry cycle counts as cycle 1. `timeout` is visible in the cycle after cycle `TIMEOUT_CYCLES`.
- `alu_done` in the same cycle as the final timeout cycle: `alu_done` wins, `timeout` = 0.
- Throughput: one operation per four presses. There is no pipelining.

## Test plan
- Multiply: presses with `sw` = 0x0003, 0x0000, 0x0005, 0x0000, `op_sel` = 0; ALU model returns 0x0000000F after 10 cycles. Required: one `alu_start`, `alu_a` = 3, `alu_b` = 5, `alu_op` = 0, then `result` = 0x0000000F and `result_valid` = 1.
- Divide by zero: a = 0x12345678, b = 0, `op_sel` = 1. Required: no `alu_start`, `result` = 0xFFFFFFFF, `div_by_zero` = 1, next cycle after the 4th press.
- Bounce: `load_n` toggling every 3 cycles for 40 cycles, then held low 100 cycles (`DEBOUNCE_CYCLES` = 16). Required: exactly one capture, `load_stage` 0→1.
- Timeout and late done: the ALU model never answers. Required: `timeout` = 1 and `result` = 0xFFFFFFFF after 64 WAIT cycles. An `alu_done` injected afterwards leaves `result` unchanged. Extra presses during WAIT leave `load_stage` unchanged.
- Reset mid-WAIT: assert `reset` one cycle during WAIT. Required: all outputs 0, `load_stage` = 0. A subsequent stale `alu_done` is ignored, and a new 4-press sequence completes normally.
- Restart from DONE: press with `sw` = 0xAAAA. Required: `result_valid` 1→0, flags cleared, `load_stage` = 1, old `result` still held.

Source files
------------

// File: rtl/arith_op_sequencer.sv
// rtl/arith_op_sequencer.sv - operand loader and operation sequencer for the mul/div unit
//
// Debounces the load key and assembles two 32-bit operands from four 16-bit
// switch captures. It then runs one start/done transaction with the
// arithmetic unit and holds the result for the display logic.
//
// Ports:
//   CLOCK_50      sole clock, rising edge
//   reset         synchronous, active-high
//   load_n        raw load key (active-low, asynchronous)
//   op_sel        0 = multiply, 1 = divide (sampled on the 4th capture)
//   sw            operand half-word
//   alu_start     one-cycle request pulse to the arithmetic unit
//   alu_op        latched op_sel
//   alu_a/alu_b   assembled operands
//   alu_done      one-cycle completion pulse from the arithmetic unit
//   alu_result    arithmetic result, valid with alu_done
//   result        held result
//   result_valid  result holds a completed operation
//   load_stage    index of the next half-word to capture
//   busy          operation in flight (ISSUE or WAIT)
//   div_by_zero   divide with b = 0, ALU skipped
//   timeout       ALU did not answer within TIMEOUT_CYCLES

module arith_op_sequencer #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        load_n,
   input  logic        op_sel,
   input  logic [15:0] sw,
   output logic        alu_start,
   output logic        alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic        alu_done,
   input  logic [31:0] alu_result,
   output logic [31:0] result,
   output logic        result_valid,
   output logic [1:0]  load_stage,
   output logic        busy,
   output logic        div_by_zero,
   output logic        timeout
);

   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DEB_W-1:0] DEB_ONE  = {{(DEB_W-1){1'b0}}, 1'b1};
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0]  TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};

   localparam logic [31:0] ERR_RESULT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state;
   logic [1:0]        sync_q;
   logic              deb_level;
   logic              deb_level_d;
   logic [DEB_W-1:0]  deb_cnt;
   logic              press;
   logic [TO_W-1:0]   wait_cnt;

   // Key path: 2-flop synchronizer, counter-based debounce, falling-edge
   // detect. press is registered so the FSM always sees a clean 1-cycle event.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync_q      <= 2'b11;
         deb_level   <= 1'b1;
         deb_level_d <= 1'b1;
         deb_cnt     <= '0;
         press       <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], load_n};
         // Level only moves after DEBOUNCE_CYCLES consecutive differing samples.
         if (sync_q[1] == deb_level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            deb_level <= sync_q[1];
            deb_cnt   <= '0;
         end else begin
            deb_cnt <= deb_cnt + DEB_ONE;
         end
         deb_level_d <= deb_level;
         press       <= deb_level_d & ~deb_level;
      end
   end

   // Sequencer with registered outputs.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state        <= S_LOAD;
         load_stage   <= 2'd0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op       <= 1'b0;
         alu_start    <= 1'b0;
         busy         <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         div_by_zero  <= 1'b0;
         timeout      <= 1'b0;
         wait_cnt     <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               if (press) begin
                  load_stage <= load_stage + 2'd1;
                  case (load_stage)
                     2'd0: alu_a[15:0]  <= sw;
                     2'd1: alu_a[31:16] <= sw;
                     2'd2: alu_b[15:0]  <= sw;
                     default: begin
                        alu_b[31:16] <= sw;
                        alu_op       <= op_sel;
                        // b is checked with this cycle's sw, not the stale upper half.
                        if (op_sel && (sw == 16'h0000) && (alu_b[15:0] == 16'h0000)) begin
                           result       <= ERR_RESULT;
                           div_by_zero  <= 1'b1;
                           result_valid <= 1'b1;
                           state        <= S_DONE;
                        end else begin
                           alu_start <= 1'b1;
                           busy      <= 1'b1;
                           state     <= S_ISSUE;
                        end
                     end
                  endcase
               end
            end

            S_ISSUE: begin
               alu_start <= 1'b0;
               wait_cnt  <= TO_ONE;   // WAIT entry cycle is cycle 1
               state     <= S_WAIT;
            end

            S_WAIT: begin
               // alu_done takes priority over the final timeout cycle.
               if (alu_done) begin
                  result       <= alu_result;
                  result_valid <= 1'b1;
                  busy         <= 1'b0;
                  state        <= S_DONE;
               end else if (wait_cnt == TO_LAST) begin
                  result       <= ERR_RESULT;
                  timeout      <= 1'b1;
                  result_valid <= 1'b1;
                  busy         <= 1'b0;
                  state        <= S_DONE;
               end else begin
                  wait_cnt <= wait_cnt + TO_ONE;
               end
            end

            S_DONE: begin
               // The restart press also counts as the first capture.
               if (press) begin
                  result_valid <= 1'b0;
                  div_by_zero  <= 1'b0;
                  timeout      <= 1'b0;
                  alu_a[15:0]  <= sw;
                  load_stage   <= 2'd1;
                  state        <= S_LOAD;
               end
            end

            default: state <= S_LOAD;
         endcase
      end
   end

endmodule
